cmpslicer: RTL and testbench

Upstream feeder for the compare ALU. Buffers one 64-row × 24-column glyph bitmap and issues the ALU `start` pulse. Streams slices to the ALU: top rows walking down, bottom rows walking up, and columns walking left to right. Paces each slice stream on the ALU's per-stream `next*` acknowledge, then captures the 16-bit result when the ALU raises `done`.

---
 rtl/cmpslicer.sv | 204 ++++++++++++++++++++
 tb/tb_cmpslicer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cmpslicer.sv
// cmpslicer -- upstream feeder for the compare ALU.
//
// Buffers one 64-row x 24-column glyph bitmap, issues the ALU start pulse and
// then streams three independent slice sequences to the ALU: columns walking
// left to right, top rows walking down and bottom rows walking up. Each stream
// advances on a rising edge of its ALU acknowledge level. The 16-bit ALU result
// is captured when the ALU raises done. A watchdog aborts a run whose streams
// are all exhausted but which never sees done.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   load_valid, load_row[23:0]    bitmap row write (bit 23 = column 0)
//   load_ready                    high while IDLE (accepting rows)
//   start                         one-cycle ALU start pulse
//   bitcolumn[63:0]               current column slice, bit r = row r
//   bitrowtop[23:0]               current top-walk row
//   bitrowbot[23:0]               current bottom-walk row
//   next*ready                    one-cycle "new slice present" pulses
//   lastcolumn                    high once column 23 is presented
//   nextcolumn/nextrowtop/nextrowbot  ALU "slice checked" levels
//   done, result[15:0]            ALU completion and result
//   result_out[15:0], res_valid   latched result and its update pulse
//   err                           one-cycle watchdog timeout pulse
module cmpslicer (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_valid,
    input  logic [23:0] load_row,
    output logic        load_ready,
    output logic        start,
    output logic [63:0] bitcolumn,
    output logic [23:0] bitrowtop,
    output logic [23:0] bitrowbot,
    output logic        nextcolumnready,
    output logic        nextrowtopready,
    output logic        nextrowbotready,
    output logic        lastcolumn,
    input  logic        nextcolumn,
    input  logic        nextrowtop,
    input  logic        nextrowbot,
    input  logic        done,
    input  logic [15:0] result,
    output logic [15:0] result_out,
    output logic        res_valid,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, START, PRIME, STREAM} state_t;

    state_t      state, state_nxt;
    logic [23:0] bitmap [64];
    logic [5:0]  load_cnt;
    logic [4:0]  col_idx;
    logic [5:0]  top_idx;
    logic [5:0]  bot_idx;
    logic [7:0]  wd_cnt;
    logic        prev_col, prev_top, prev_bot;

    logic        load_fire;
    logic        col_end, top_end, bot_end, all_end;
    logic        col_adv, top_adv, bot_adv;
    logic        wd_fire;
    logic [4:0]  col_sel;
    logic [63:0] col_slice;

    assign load_fire = (state == IDLE) && load_valid;

    // Exhaustion points; the walk stops there and later edges are ignored.
    assign col_end = (col_idx == 5'd23);
    assign top_end = (top_idx == 6'd63);
    assign bot_end = (bot_idx == 6'd0);
    assign all_end = col_end && top_end && bot_end;

    assign col_adv = nextcolumn && !prev_col && !col_end;
    assign top_adv = nextrowtop && !prev_top && !top_end;
    assign bot_adv = nextrowbot && !prev_bot && !bot_end;

    // Fires on the 255th stalled cycle (count runs 0..254 before it).
    assign wd_fire = (state == STREAM) && !done && all_end && (wd_cnt == 8'd254);

    // Column about to be driven: column 0 when priming, otherwise the next one.
    // NOTE: every always_comb output gets a value on every path, so no latches.
    always_comb begin
        col_sel   = (state == STREAM) ? col_idx + 5'd1 : 5'd0;
        col_slice = '0;
        for (int r = 0; r < 64; r++) begin
            col_slice[r] = bitmap[r][5'd23 - col_sel];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load_fire && load_cnt == 6'd63) state_nxt = START;
            START:   state_nxt = PRIME;
            PRIME:   state_nxt = STREAM;
            STREAM:  if (done || wd_fire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: the bitmap buffer has no reset; a fresh load always overwrites it.
    always_ff @(posedge clk) begin
        if (load_fire) begin
            bitmap[load_cnt] <= load_row;
        end
    end

    // NOTE: all state and outputs update with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            load_cnt        <= '0;
            col_idx         <= '0;
            top_idx         <= '0;
            bot_idx         <= '0;
            wd_cnt          <= '0;
            prev_col        <= 1'b0;
            prev_top        <= 1'b0;
            prev_bot        <= 1'b0;
            load_ready      <= 1'b1;
            start           <= 1'b0;
            bitcolumn       <= '0;
            bitrowtop       <= '0;
            bitrowbot       <= '0;
            nextcolumnready <= 1'b0;
            nextrowtopready <= 1'b0;
            nextrowbotready <= 1'b0;
            lastcolumn      <= 1'b0;
            result_out      <= '0;
            res_valid       <= 1'b0;
            err             <= 1'b0;
        end else begin
            state           <= state_nxt;
            load_ready      <= (state_nxt == IDLE);
            start           <= (state_nxt == START);
            nextcolumnready <= 1'b0;
            nextrowtopready <= 1'b0;
            nextrowbotready <= 1'b0;
            res_valid       <= 1'b0;
            err             <= 1'b0;

            case (state)
                IDLE: begin
                    if (load_fire) begin
                        // Wraps to 0 after row 63, ready for the next load.
                        load_cnt <= load_cnt + 6'd1;
                        if (load_cnt == 6'd63) lastcolumn <= 1'b0;
                    end
                end
                START: begin
                    // Register the first slices so they appear during PRIME.
                    col_idx         <= '0;
                    top_idx         <= '0;
                    bot_idx         <= 6'd63;
                    wd_cnt          <= '0;
                    bitcolumn       <= col_slice;
                    bitrowtop       <= bitmap[0];
                    bitrowbot       <= bitmap[63];
                    nextcolumnready <= 1'b1;
                    nextrowtopready <= 1'b1;
                    nextrowbotready <= 1'b1;
                end
                PRIME: begin
                    // Levels left high by the previous run must not count as edges.
                    prev_col <= 1'b1;
                    prev_top <= 1'b1;
                    prev_bot <= 1'b1;
                end
                STREAM: begin
                    prev_col <= nextcolumn;
                    prev_top <= nextrowtop;
                    prev_bot <= nextrowbot;
                    if (done) begin
                        result_out <= result;
                        res_valid  <= 1'b1;
                    end else if (wd_fire) begin
                        err <= 1'b1;
                    end else begin
                        if (col_adv) begin
                            col_idx         <= col_idx + 5'd1;
                            bitcolumn       <= col_slice;
                            nextcolumnready <= 1'b1;
                            if (col_idx == 5'd22) lastcolumn <= 1'b1;
                        end
                        if (top_adv) begin
                            top_idx         <= top_idx + 6'd1;
                            bitrowtop       <= bitmap[top_idx + 6'd1];
                            nextrowtopready <= 1'b1;
                        end
                        if (bot_adv) begin
                            bot_idx         <= bot_idx - 6'd1;
                            bitrowbot       <= bitmap[bot_idx - 6'd1];
                            nextrowbotready <= 1'b1;
                        end
                        if (all_end) wd_cnt <= wd_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cmpslicer.sv
// Self-checking bench for cmpslicer: directed load/prime/done/watchdog/reset
// scenarios with randomized acknowledge levels and bitmaps, checked against a
// slice-index model of the three walks.
module tb_cmpslicer;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_valid;
    logic [23:0] load_row;
    logic        load_ready;
    logic        start;
    logic [63:0] bitcolumn;
    logic [23:0] bitrowtop;
    logic [23:0] bitrowbot;
    logic        nextcolumnready, nextrowtopready, nextrowbotready;
    logic        lastcolumn;
    logic        nextcolumn, nextrowtop, nextrowbot;
    logic        done;
    logic [15:0] result;
    logic [15:0] result_out;
    logic        res_valid;
    logic        err;

    always #5 clk = ~clk;

    cmpslicer dut (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .load_row(load_row), .load_ready(load_ready),
        .start(start),
        .bitcolumn(bitcolumn), .bitrowtop(bitrowtop), .bitrowbot(bitrowbot),
        .nextcolumnready(nextcolumnready), .nextrowtopready(nextrowtopready),
        .nextrowbotready(nextrowbotready), .lastcolumn(lastcolumn),
        .nextcolumn(nextcolumn), .nextrowtop(nextrowtop), .nextrowbot(nextrowbot),
        .done(done), .result(result),
        .result_out(result_out), .res_valid(res_valid), .err(err)
    );

    int          checks = 0;
    int          failures = 0;
    int          gcyc = 0;
    logic [23:0] bm [64];
    int          mcol, mtop, mbot;
    logic        mp_col, mp_top, mp_bot;
    int          col_pulses;
    int          first_exh;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        gcyc++;
    endtask

    // Column c = pixel (23-c) of every row, row r at bit r.
    function automatic logic [63:0] exp_col(input int c);
        logic [63:0] v;
        for (int r = 0; r < 64; r++) v[r] = bm[r][23 - c];
        return v;
    endfunction

    task automatic check_reset_vals();
        check("rst_load_ready", load_ready, 1'b1);
        check("rst_start", start, 1'b0);
        check("rst_bitcolumn", bitcolumn, 64'h0);
        check("rst_bitrowtop", bitrowtop, 24'h0);
        check("rst_bitrowbot", bitrowbot, 24'h0);
        check("rst_readies", {nextcolumnready, nextrowtopready, nextrowbotready}, 3'b000);
        check("rst_lastcolumn", lastcolumn, 1'b0);
        check("rst_result_out", result_out, 16'h0);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_err", err, 1'b0);
    endtask

    // Loads bm, checks start timing and the PRIME cycle, ends in first STREAM cycle.
    task automatic load_bitmap();
        for (int i = 0; i < 64; i++) begin
            load_valid = 1'b1;
            load_row   = bm[i];
            step();
            if (i < 63) check("no_early_start", start, 1'b0);
        end
        // Keep pushing garbage: it must be ignored outside IDLE.
        load_row = 24'hFFFFFF;
        check("start_pulse", start, 1'b1);
        check("load_ready_start", load_ready, 1'b0);
        step();
        load_valid = 1'b0;
        load_row   = 24'h0;
        check("prime_start_low", start, 1'b0);
        check("prime_readies", {nextcolumnready, nextrowtopready, nextrowbotready}, 3'b111);
        check("prime_col0", bitcolumn, exp_col(0));
        check("prime_top0", bitrowtop, bm[0]);
        check("prime_bot63", bitrowbot, bm[63]);
        check("prime_lastcolumn", lastcolumn, 1'b0);
        step();
        check("stream_readies_low", {nextcolumnready, nextrowtopready, nextrowbotready}, 3'b000);
        mcol = 0; mtop = 0; mbot = 63;
        mp_col = 1'b1; mp_top = 1'b1; mp_bot = 1'b1;
        col_pulses = 0;
        first_exh  = -1;
    endtask

    // mode 0: column toggles every 2 cycles, top/bot rise together at k=1 then random
    // mode 1: all three toggle every cycle; mode 2: all random
    task automatic run_stream(input int ncyc, input int mode);
        logic dc, dt, db, rc, rt, rb;
        for (int k = 0; k < ncyc; k++) begin
            case (mode)
                0: begin
                    dc = ((k / 2) % 2) == 1;
                    if (k < 2) begin dt = (k == 1); db = (k == 1); end
                    else begin dt = 1'($urandom % 2); db = 1'($urandom % 2); end
                end
                1: begin dc = (k % 2) == 1; dt = dc; db = dc; end
                default: begin
                    dc = 1'($urandom % 2); dt = 1'($urandom % 2); db = 1'($urandom % 2);
                end
            endcase
            nextcolumn = dc; nextrowtop = dt; nextrowbot = db;
            done = 1'b0;
            rc = dc && !mp_col && (mcol < 23);
            rt = dt && !mp_top && (mtop < 63);
            rb = db && !mp_bot && (mbot > 0);
            mp_col = dc; mp_top = dt; mp_bot = db;
            if (rc) mcol++;
            if (rt) mtop++;
            if (rb) mbot--;
            step();
            if (nextcolumnready) col_pulses++;
            check("col_ready", nextcolumnready, rc);
            check("top_ready", nextrowtopready, rt);
            check("bot_ready", nextrowbotready, rb);
            check("col_data", bitcolumn, exp_col(mcol));
            check("top_data", bitrowtop, bm[mtop]);
            check("bot_data", bitrowbot, bm[mbot]);
            check("lastcolumn", lastcolumn, mcol == 23);
            check("stream_no_res_valid", res_valid, 1'b0);
            check("stream_no_err", err, 1'b0);
            if (mode == 0 && rc && mcol == 3) check("col3_row10", bitcolumn, 64'h400);
            if (mode == 0 && k == 1) begin
                check("simul_readies", {nextrowtopready, nextrowbotready}, 2'b11);
                check("simul_top_row1", bitrowtop, bm[1]);
                check("simul_bot_row62", bitrowbot, bm[62]);
            end
            if (first_exh < 0 && mcol == 23 && mtop == 63 && mbot == 0) first_exh = gcyc;
        end
    endtask

    task automatic finish_done(input logic [15:0] r);
        done   = 1'b1;
        result = r;
        step();
        done   = 1'b0;
        result = 16'hBEEF;
        check("done_result_out", result_out, r);
        check("done_res_valid", res_valid, 1'b1);
        check("done_load_ready", load_ready, 1'b1);
        step();
        check("res_valid_pulse", res_valid, 1'b0);
        check("result_out_hold", result_out, r);
    endtask

    initial begin
        int got;
        logic [15:0] rnd_res;
        rst = 1'b1; load_valid = 1'b0; load_row = '0;
        nextcolumn = 1'b0; nextrowtop = 1'b0; nextrowbot = 1'b0;
        done = 1'b0; result = '0;
        step();
        step();
        rst = 1'b0;
        check_reset_vals();

        // Run 1: directed bitmap, column walk pacing, simultaneous top/bot, done.
        for (int i = 0; i < 64; i++) bm[i] = 24'h0;
        bm[10] = 24'h100000;
        load_bitmap();
        run_stream(120, 0);
        check("col_pulse_count", col_pulses, 23);
        finish_done(16'h1A23);
        // done outside STREAM is ignored.
        done = 1'b1; result = 16'h5555;
        step();
        done = 1'b0;
        check("idle_done_no_valid", res_valid, 1'b0);
        check("idle_done_no_update", result_out, 16'h1A23);

        // Run 2: all-zero bitmap, ALU never finishes -> watchdog.
        for (int i = 0; i < 64; i++) bm[i] = 24'h0;
        load_bitmap();
        run_stream(130, 1);
        check("all_exhausted", first_exh >= 0, 1'b1);
        got = 0;
        while (got == 0 && gcyc < first_exh + 400) begin
            step();
            if (err) got = 1;
            else check("wd_no_res_valid", res_valid, 1'b0);
        end
        check("wd_err_cycle", gcyc, first_exh + 255);
        check("wd_result_kept", result_out, 16'h1A23);
        check("wd_load_ready", load_ready, 1'b1);
        check("wd_no_res_valid_at_err", res_valid, 1'b0);
        step();
        check("wd_err_pulse", err, 1'b0);

        // Run 3: reset at load row 30.
        for (int i = 0; i < 64; i++) bm[i] = 24'($urandom);
        for (int i = 0; i <= 30; i++) begin
            load_valid = 1'b1;
            load_row   = bm[i];
            if (i == 30) rst = 1'b1;
            step();
        end
        rst = 1'b0;
        load_valid = 1'b0;
        check_reset_vals();
        step();
        check("post_rst_no_start", start, 1'b0);

        // Fresh full load must take exactly 64 rows, then reset mid-stream.
        for (int i = 0; i < 64; i++) bm[i] = 24'($urandom);
        load_bitmap();
        run_stream(60, 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_vals();
        step();
        check("post_rst2_no_valid", res_valid, 1'b0);
        check("post_rst2_no_err", err, 1'b0);
        check("post_rst2_idle", load_ready, 1'b1);

        // Full reload completes normally.
        for (int i = 0; i < 64; i++) bm[i] = 24'($urandom);
        load_bitmap();
        run_stream(80, 2);
        rnd_res = 16'($urandom);
        finish_done(rnd_res);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
